// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the multicycle ARM-subset processor. A Moore state machine
// walks each instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK.
// The unit also holds the NZCV flags register and the latched condition result
// (cond_q) of the instruction in flight.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   Instr       in   instruction register contents (Cond, Op, Funct, Rd used)
//   ALUFlags    in   NZCV from the ALU in the current cycle
//   PCWrite     out  PC register enable
//   MemWrite    out  data memory write enable
//   RegWrite    out  register file WE3
//   IRWrite     out  instruction register enable
//   AdrSrc      out  memory address select: 0 = PC, 1 = Result
//   ALUSrcA     out  0 = RD1 latch, 1 = PC
//   ALUSrcB     out  00 = RD2 latch, 01 = ExtImm, 10 = constant 4
//   ResultSrc   out  00 = ALUOut, 01 = Data register, 10 = ALUResult
//   ImmSrc      out  immediate format, equal to Op
//   RegSrc      out  [0] RA1 = 15 (branch), [1] RA2 = Rd (store)
//   ALUControl  out  00 ADD, 01 SUB, 10 AND, 11 ORR
//
// The current state is held in the internal signal 'state' so checkers can
// bind to it directly.
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state;
    logic [3:0] flags;    // {N, Z, C, V}
    logic       cond_q;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       s_bit;
    logic       u_bit;
    logic       l_bit;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cmd   = funct[4:1];
    assign rd    = Instr[15:12];
    assign s_bit = funct[0];
    assign l_bit = funct[0];
    assign u_bit = funct[3];

    // Register-number and immediate fields belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    // Data-processing command decode
    logic       supported;
    logic       arith_cmd;     // ADD or SUB: the only commands that own C and V
    logic [1:0] dp_alu;

    always_comb begin
        supported = 1'b1;
        arith_cmd = 1'b0;
        dp_alu    = 2'b00;
        case (cmd)
            4'b0100: begin dp_alu = 2'b00; arith_cmd = 1'b1; end
            4'b0010: begin dp_alu = 2'b01; arith_cmd = 1'b1; end
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
            default: supported = 1'b0;
        endcase
    end

    // ARM condition evaluation against the flags register
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cy;
            4'b0011: cond_eval = ~cy;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cy & ~z;
            4'b1001: cond_eval = ~cy | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // State, flags and condition latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            flags  <= 4'b0000;
            cond_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    cond_q <= cond_eval(cond, flags);
                    case (op)
                        2'b01:   state <= S_MEMADR;
                        2'b00:   state <= funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   state <= S_BRANCH;
                        default: state <= S_FETCH;   // undefined, no side effects
                    endcase
                end
                S_MEMADR: state <= l_bit ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_EXECUTER, S_EXECUTEI: begin
                    state <= S_ALUWB;
                    // cond_q is left alone: the update only affects later instructions
                    if (s_bit && cond_q && supported) begin
                        flags[3:2] <= ALUFlags[3:2];
                        if (arith_cmd)
                            flags[1:0] <= ALUFlags[1:0];
                    end
                end
                default: state <= S_FETCH;   // MEMWB, MEMWR, ALUWB, BRANCH
            endcase
        end
    end

    // Moore outputs. During reset the FETCH decode is shown with all
    // enables held low, whatever state the machine was in.
    logic   reg_we;
    state_t out_state;

    always_comb begin
        out_state  = rst ? S_FETCH : state;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        reg_we     = 1'b0;
        ImmSrc     = op;
        RegSrc     = {(op == 2'b01) & ~l_bit, op == 2'b10};

        case (out_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                // PC+8 is formed here and serves as the R15 read value
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = u_bit ? 2'b00 : 2'b01;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = cond_q;
                RegWrite  = reg_we;
                PCWrite   = reg_we & (rd == 4'd15);
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_q;
            end
            S_EXECUTER: begin
                ALUSrcB    = 2'b00;
                ALUControl = dp_alu;
            end
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                reg_we    = cond_q & supported;
                RegWrite  = reg_we;
                PCWrite   = reg_we & (rd == 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 2'b00;
                ResultSrc  = 2'b10;
                PCWrite    = cond_q;
            end
            default: ;
        endcase

        if (rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Cycle-by-cycle directed vectors for multicycle_controller. Each row gives
// the inputs for one clock cycle and the hand-computed output vector
// {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
//  ResultSrc, ImmSrc, RegSrc, ALUControl} expected during that cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] act;
    assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [3:0]  flags;
        logic [15:0] exp;
        logic [15:0] mask;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    localparam logic [15:0] MALL   = 16'hFFFF;
    localparam logic [15:0] MNOALU = 16'hFFFC;   // ALUControl is free for unsupported cmds

    function automatic logic [15:0] ov(input logic pcw, mw, rw, irw, adr, srca,
                                       input logic [1:0] srcb, res, imm, rsrc, aluc);
        return {pcw, mw, rw, irw, adr, srca, srcb, res, imm, rsrc, aluc};
    endfunction

    function automatic void add(input logic r, input logic [31:0] i,
                                input logic [3:0] f, input logic [15:0] e,
                                input logic [15:0] m = MALL);
        vec_t v;
        v.rst = r; v.instr = i; v.flags = f; v.exp = e; v.mask = m;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, compare on the falling edge, advance past the next rising edge.
    task automatic step_check(input logic r, input logic [31:0] i, input logic [3:0] f,
                              input logic [15:0] e, input logic [15:0] m);
        rst      = r;
        Instr    = i;
        ALUFlags = f;
        @(negedge clk);
        checks++;
        if ((act & m) !== (e & m)) begin
            errors++;
            $display("FAIL row %0d instr=%h rst=%0b outputs got=%h want=%h mask=%h",
                     row, i, r, act, e, m);
        end
        row++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        Instr    = 32'h0;
        ALUFlags = 4'h0;

        // reset: enables low, FETCH muxes
        add(1, 32'hE0821003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(1, 32'hE0821003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        // ADD R1,R2,R3 (S=0, ALU reports Z=1 which must be ignored)
        add(0, 32'hE0821003, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'hE0821003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'hE0821003, 4'h4, ov(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 32'hE0821003, 4'h9, ov(0,0,1,0,0,0,0,0,0,0,0));
        // BEQ with flags cleared by reset: not taken
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,0,1,2,2,1,0));
        // SUBS R0,R0,#1, ALU NZCV=0110
        add(0, 32'hE2500001, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'hE2500001, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'hE2500001, 4'h6, ov(0,0,0,0,0,0,1,0,0,0,1));
        add(0, 32'hE2500001, 4'h9, ov(0,0,1,0,0,0,0,0,0,0,0));
        // BEQ taken
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,0,0,0,1,2,2,1,0));
        // BNE not taken
        add(0, 32'h1A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h1A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h1A000000, 4'h9, ov(0,0,0,0,0,0,1,2,2,1,0));
        // LDR R4,[R5,#8]
        add(0, 32'hE5954008, 4'h9, ov(1,0,0,1,0,1,2,2,1,0,0));
        add(0, 32'hE5954008, 4'h9, ov(0,0,0,0,0,1,2,2,1,0,0));
        add(0, 32'hE5954008, 4'h9, ov(0,0,0,0,0,0,1,0,1,0,0));
        add(0, 32'hE5954008, 4'h9, ov(0,0,0,0,1,0,0,0,1,0,0));
        add(0, 32'hE5954008, 4'h9, ov(0,0,1,0,0,0,0,1,1,0,0));
        // STR R4,[R5,#8]
        add(0, 32'hE5854008, 4'h9, ov(1,0,0,1,0,1,2,2,1,2,0));
        add(0, 32'hE5854008, 4'h9, ov(0,0,0,0,0,1,2,2,1,2,0));
        add(0, 32'hE5854008, 4'h9, ov(0,0,0,0,0,0,1,0,1,2,0));
        add(0, 32'hE5854008, 4'h9, ov(0,1,0,0,1,0,0,0,1,2,0));
        // LDR R4,[R5,#-8]: address computed with SUB
        add(0, 32'hE5154008, 4'h9, ov(1,0,0,1,0,1,2,2,1,0,0));
        add(0, 32'hE5154008, 4'h9, ov(0,0,0,0,0,1,2,2,1,0,0));
        add(0, 32'hE5154008, 4'h9, ov(0,0,0,0,0,0,1,0,1,0,1));
        add(0, 32'hE5154008, 4'h9, ov(0,0,0,0,1,0,0,0,1,0,0));
        add(0, 32'hE5154008, 4'h9, ov(0,0,1,0,0,0,0,1,1,0,0));
        // ADDSNE R1,R2,R3 with Z=1: skipped, flags must stay 0110
        add(0, 32'h10921003, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'h10921003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'h10921003, 4'h9, ov(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 32'h10921003, 4'h9, ov(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,0,0,0,1,2,2,1,0));
        // unsupported cmd 1111 with S=1: no RegWrite, no flag update
        add(0, 32'hE1F01002, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'hE1F01002, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'hE1F01002, 4'h9, ov(0,0,0,0,0,0,0,0,0,0,0), MNOALU);
        add(0, 32'hE1F01002, 4'h9, ov(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,0,0,0,1,2,2,1,0));
        // ANDS R1,R2,R3 with ALU NZCV=1001: flags become N1 Z0 C1 V0
        add(0, 32'hE0121003, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'hE0121003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'hE0121003, 4'h9, ov(0,0,0,0,0,0,0,0,0,0,2));
        add(0, 32'hE0121003, 4'h9, ov(0,0,1,0,0,0,0,0,0,0,0));
        // BCS taken (C kept), BLT taken (V kept), BEQ not taken (Z cleared)
        add(0, 32'h2A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h2A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h2A000000, 4'h9, ov(1,0,0,0,0,0,1,2,2,1,0));
        add(0, 32'hBA000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'hBA000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'hBA000000, 4'h9, ov(1,0,0,0,0,0,1,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0));
        add(0, 32'h0A000000, 4'h9, ov(0,0,0,0,0,0,1,2,2,1,0));
        // ORR R2,R1,#3 (immediate form)
        add(0, 32'hE3812003, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'hE3812003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'hE3812003, 4'h9, ov(0,0,0,0,0,0,1,0,0,0,3));
        add(0, 32'hE3812003, 4'h9, ov(0,0,1,0,0,0,0,0,0,0,0));
        // undefined Op=11: two cycles
        add(0, 32'hEC000000, 4'h9, ov(1,0,0,1,0,1,2,2,3,0,0));
        add(0, 32'hEC000000, 4'h9, ov(0,0,0,0,0,1,2,2,3,0,0));
        // ADD R15,R2,R3: write to PC also enables PCWrite
        add(0, 32'hE082F003, 4'h9, ov(1,0,0,1,0,1,2,2,0,0,0));
        add(0, 32'hE082F003, 4'h9, ov(0,0,0,0,0,1,2,2,0,0,0));
        add(0, 32'hE082F003, 4'h9, ov(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 32'hE082F003, 4'h9, ov(1,0,1,0,0,0,0,0,0,0,0));

        foreach (vecs[k])
            step_check(vecs[k].rst, vecs[k].instr, vecs[k].flags, vecs[k].exp, vecs[k].mask);

        // STR R4,[R5,#-8] aborted by reset in MEMWR
        step_check(0, 32'hE5054008, 4'h9, ov(1,0,0,1,0,1,2,2,1,2,0), MALL);
        step_check(0, 32'hE5054008, 4'h9, ov(0,0,0,0,0,1,2,2,1,2,0), MALL);
        step_check(0, 32'hE5054008, 4'h9, ov(0,0,0,0,0,0,1,0,1,2,1), MALL);
        step_check(1, 32'hE5054008, 4'h9, ov(0,0,0,0,0,1,2,2,1,2,0), MALL);
        step_check(0, 32'hE5054008, 4'h9, ov(1,0,0,1,0,1,2,2,1,2,0), MALL);
        step_check(0, 32'hE5054008, 4'h9, ov(0,0,0,0,0,1,2,2,1,2,0), MALL);
        step_check(0, 32'hE5054008, 4'h9, ov(0,0,0,0,0,0,1,0,1,2,1), MALL);
        step_check(0, 32'hE5054008, 4'h9, ov(0,1,0,0,1,0,0,0,1,2,0), MALL);

        // reset cleared C: BCS not taken
        step_check(0, 32'h2A000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0), MALL);
        step_check(0, 32'h2A000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0), MALL);
        step_check(0, 32'h2A000000, 4'h9, ov(0,0,0,0,0,0,1,2,2,1,0), MALL);

        // AL branch always taken, 1111 condition never taken
        step_check(0, 32'hEA000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0), MALL);
        step_check(0, 32'hEA000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0), MALL);
        step_check(0, 32'hEA000000, 4'h9, ov(1,0,0,0,0,0,1,2,2,1,0), MALL);
        step_check(0, 32'hFA000000, 4'h9, ov(1,0,0,1,0,1,2,2,2,1,0), MALL);
        step_check(0, 32'hFA000000, 4'h9, ov(0,0,0,0,0,1,2,2,2,1,0), MALL);
        step_check(0, 32'hFA000000, 4'h9, ov(0,0,0,0,0,0,1,2,2,1,0), MALL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
